// File: rtl/data_memory_mmio.sv
// data_memory_mmio
// Word-addressed data memory responder for the single-cycle MIPS-32 core.
// Loads are answered combinationally in the same cycle. Stores commit at the
// rising edge of Clk. Low addresses map to a RAM array. A 16-byte register
// window at MMIO_BASE holds four registers:
//   0x0 OUT          output port register
//   0x4 COUNT        free-running timer, loadable
//   0x8 CMP          timer compare value
//   0xC CTRL_STATUS  bit0 enable, bit1 match (W1C), bit2 error (W1C)
// Ports:
//   Clk        system clock; all state changes on the rising edge
//   reset      asynchronous active-high reset of all registers (RAM excluded)
//   Address    byte address from the core
//   WriteData  store data
//   MemWrite   store strobe
//   MemRead    load strobe; qualifies ReadData
//   ReadData   combinational load data (0 when not reading or illegal)
//   out_port   current OUT register
//   timer_irq  level copy of STATUS.match
//   err        level copy of STATUS.error
module data_memory_mmio #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF0000
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic [31:0] out_port,
  output logic        timer_irq,
  output logic        err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  localparam logic [1:0] SEL_OUT   = 2'd0;
  localparam logic [1:0] SEL_COUNT = 2'd1;
  localparam logic [1:0] SEL_CMP   = 2'd2;
  localparam logic [1:0] SEL_CTRL  = 2'd3;

  // Storage
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] out_reg;
  logic [31:0] count_reg;
  logic [31:0] cmp_reg;
  logic        enable;
  logic        match;
  logic        error;

  // Address decode
  logic          access;
  logic          ram_hit;
  logic          mmio_hit;
  logic          misaligned;
  logic          illegal;
  logic          ram_we;
  logic          mmio_we;
  logic [AW-1:0] word_idx;
  logic [1:0]    reg_sel;

  always_comb begin
    access     = MemRead | MemWrite;
    ram_hit    = (Address < RAM_BYTES);
    mmio_hit   = (Address[31:4] == MMIO_BASE[31:4]);
    misaligned = (Address[1:0] != 2'b00);
    illegal    = access & (misaligned | ~(ram_hit | mmio_hit));
    ram_we     = MemWrite & ~illegal & ram_hit;
    mmio_we    = MemWrite & ~illegal & mmio_hit;
    word_idx   = Address[AW+1:2];
    reg_sel    = Address[3:2];
  end

  // Next timer value when nothing overrides it: wrap to 0 on compare hit,
  // otherwise count up (modulo 2^32); hold while disabled.
  function automatic logic [31:0] timer_next(input logic        en,
                                             input logic [31:0] cnt,
                                             input logic [31:0] cmp);
    logic [31:0] nxt;
    nxt = cnt;
    if (en) begin
      if (cnt == cmp) nxt = 32'd0;
      else            nxt = cnt + 32'd1;
    end
    return nxt;
  endfunction

  // Write-1-to-clear with a hardware set that wins over a same-edge clear.
  function automatic logic sticky_next(input logic cur,
                                       input logic hw_set,
                                       input logic w1c);
    return hw_set | (cur & ~w1c);
  endfunction

  logic hw_match;
  logic ctrl_we;

  always_comb begin
    hw_match = enable & (count_reg == cmp_reg);
    ctrl_we  = mmio_we & (reg_sel == SEL_CTRL);
  end

  // RAM: not reset; stores are ignored while reset is asserted
  always_ff @(posedge Clk) begin
    if (ram_we && !reset) mem[word_idx] <= WriteData;
  end

  // Register window and timer
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      out_reg   <= 32'd0;
      count_reg <= 32'd0;
      cmp_reg   <= 32'hFFFFFFFF;
      enable    <= 1'b0;
      match     <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (mmio_we && reg_sel == SEL_OUT) out_reg <= WriteData;
      if (mmio_we && reg_sel == SEL_CMP) cmp_reg <= WriteData;

      // A software load of COUNT overrides increment and wrap
      if (mmio_we && reg_sel == SEL_COUNT) count_reg <= WriteData;
      else count_reg <= timer_next(enable, count_reg, cmp_reg);

      if (ctrl_we) enable <= WriteData[0];
      match <= sticky_next(match, hw_match, ctrl_we & WriteData[1]);
      error <= sticky_next(error, illegal,  ctrl_we & WriteData[2]);
    end
  end

  // Combinational read path, showing pre-edge contents
  always_comb begin
    ReadData = 32'd0;
    if (MemRead && !illegal) begin
      if (ram_hit) begin
        ReadData = mem[word_idx];
      end else if (mmio_hit) begin
        case (reg_sel)
          SEL_OUT:   ReadData = out_reg;
          SEL_COUNT: ReadData = count_reg;
          SEL_CMP:   ReadData = cmp_reg;
          default:   ReadData = {29'd0, error, match, enable};
        endcase
      end
    end
  end

  assign out_port  = out_reg;
  assign timer_irq = match;
  assign err       = error;

endmodule
